jtframe_frac_cen_gen: RTL
=========================

// Module: jtframe_frac_cen_gen
// PURPOSE
//  Fractional clock-enable generator with a divided-enable tree and a runtime-programmable ratio.
//  Each system clock adds STEP to an accumulator. A wrap past LIM yields one cen[0] pulse, so the
//  mean rate is f_clk*STEP/LIM. cen[k] pulses once every 2^k cen[0] pulses, phase-aligned to cen[0].
//  Drives chip cores (e.g. jt51 cen/cen_p1) and test benches. Ratio can change without resynthesis.
// PARAMETERS
//  W        11    accumulator/step/limit width (bits)
//  N        2     number of enable outputs (cen[0]=full rate, cen[N-1]=full/2^(N-1)); N>=1
//  STEP0    105   step loaded at reset (48 MHz*105/1408 = 3.579545 MHz)
//  LIM0     1408  limit loaded at reset
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous reset, active low
//  cfg_we    in   1   load cfg_step/cfg_lim this cycle
//  cfg_step  in   W   new step value
//  cfg_lim   in   W   new limit value
//  stall     in   1   only with JTFRAME_FRACCEN_STALL_EN: freeze generator
//  cen       out  N   registered one-cycle enable pulses
//  cen_idx   out  N-1 free-running pulse index (div counter); width max(N-1,1)
// BEHAVIOUR
//  Reset (rst_n=0, async): cnt=0, div=0, step=STEP0, lim=LIM0, cen=0. Outputs are 0 while rst_n=0.
//  Per clock, with next = cnt+step (W+1 bits, no overflow loss):
//   - recovery: if cnt >= lim+step, then cnt<=0, div<=0, cen<=0 (self-heal from corrupted state)
//   - else if next >= lim: cnt<=next-lim; cen[0]<=1; div<=div+1 (wraps mod 2^(N-1));
//     cen[k]<=1 (k>=1) iff div[k-1:0] is all ones before the increment
//   - else: cnt<=next; cen<=0
//  cen is registered. The first cen[0] after reset release appears on rising edge ceil(LIM/STEP).
//  cen[k] is never high unless cen[0] is high in the same cycle. No cen bit is high two cycles in a row
//  unless step >= lim.
//  Config: cfg_we=1 loads step/lim at the clock edge and clears cnt=0, div=0, cen=0. It has priority
//  over accumulation and recovery. New ratio takes effect from the next cycle.
//  Degenerate configs:
//   - step=0: cen stays 0 forever, no error
//   - step>=lim (lim>0): cen[0]=1 every cycle, cnt stays 0, divided outputs keep their ratio
//   - lim=0: treated as step>=lim
//  Widths: all compares are unsigned on W+1 bits. lim+step is computed on W+1 bits.
//  cen_idx=div. With N=1, cen_idx is tied 0 and there is no div register.
// CONFIGURATION
//  JTFRAME_FRACCEN_STALL_EN defined: stall port exists. stall=1 holds cnt/div and forces cen=0.
//   cfg_we still acts during stall. Release resumes the exact sequence, losing no phase.
//  Undefined: no stall port. Generator always runs.
// TESTING
//  1 Defaults, 48 MHz clk, release rst_n -> first cen[0] on edge 14 (cnt=62 after it);
//    over 2816 clocks exactly 210 cen[0] and 105 cen[1] pulses.
//  2 N=3, cfg_we with step=1, lim=4 -> cen[0] every 4th clock, cen[1] every 8th, cen[2] every 16th,
//    all coincident with cen[0].
//  3 cfg_we with step=5, lim=5, then step=0 -> cen[0]=1 each cycle, then all cen 0 permanently.
//  4 Assert rst_n=0 mid-period (cnt!=0, between clock edges) -> cen=0 immediately;
//    after release, sequence identical to test 1.
//  5 Force cnt=2047 with defaults -> next cycle cnt=0, div=0, no pulse; then normal 14-cycle first pulse.
//  6 With JTFRAME_FRACCEN_STALL_EN, stall 100 cycles mid-run -> no pulses during stall;
//    pulse timeline afterwards equals the unstalled one shifted by 100 cycles.

Source files
------------

// File: rtl/jtframe_frac_cen_gen.sv
// Fractional clock-enable generator: cen[0] averages f_clk*step/lim, cen[k] divides it by 2^k.
// Define JTFRAME_FRACCEN_STALL_EN to add a stall input that freezes the generator without losing phase.
module jtframe_frac_cen_gen #(
   parameter int          W     = 11,
   parameter int          N     = 2,
   parameter int unsigned STEP0 = 105,
   parameter int unsigned LIM0  = 1408,
   localparam int         DW    = (N > 1) ? N - 1 : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [W-1:0]  cfg_step,
   input  logic [W-1:0]  cfg_lim,
`ifdef JTFRAME_FRACCEN_STALL_EN
   input  logic          stall,
`endif
   output logic [N-1:0]  cen,
   output logic [DW-1:0] cen_idx
);

   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  step_q, step_d;
   logic [W-1:0]  lim_q, lim_d;
   logic [N-1:0]  cen_q, cen_d;
   logic [DW-1:0] div_q, div_d;
   logic [W:0]    next_w, lim_step_w, diff_w;
   logic [N-1:0]  tap_w;
   logic          run_w;

`ifdef JTFRAME_FRACCEN_STALL_EN
   assign run_w = ~stall;
`else
   assign run_w = 1'b1;
`endif

   assign next_w     = {1'b0, cnt_q} + {1'b0, step_q};
   assign lim_step_w = {1'b0, lim_q} + {1'b0, step_q};
   assign diff_w     = next_w - {1'b0, lim_q};

   // Pulse pattern for one cen[0] event: cen[k] fires when the low k div bits are all ones
   assign tap_w[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < N; gi++) begin : g_tap
         assign tap_w[gi] = &div_q[gi-1:0];
      end
   endgenerate

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      step_d = step_q;
      lim_d  = lim_q;
      cen_d  = '0;
      if (cfg_we) begin
         step_d = cfg_step;
         lim_d  = cfg_lim;
         cnt_d  = '0;
         div_d  = '0;
      end else if (!run_w) begin
         cnt_d = cnt_q;
      end else if ({1'b0, cnt_q} >= lim_step_w) begin
         // Unreachable from a sane state; also swallows step=0,lim=0
         cnt_d = '0;
         div_d = '0;
      end else if (step_q >= lim_q) begin
         cnt_d = '0;
         cen_d = tap_w;
         div_d = div_q + DW'(1);
      end else if (next_w >= {1'b0, lim_q}) begin
         cnt_d = diff_w[W-1:0];
         cen_d = tap_w;
         div_d = div_q + DW'(1);
      end else begin
         cnt_d = next_w[W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         step_q <= W'(STEP0);
         lim_q  <= W'(LIM0);
         cen_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
         lim_q  <= lim_d;
         cen_q  <= cen_d;
      end
   end

   generate
      if (N > 1) begin : g_div
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) div_q <= '0;
            else        div_q <= div_d;
         end
      end else begin : g_nodiv
         assign div_q = '0;
      end
   endgenerate

   assign cen     = cen_q;
   assign cen_idx = div_q;

endmodule
